// File: rtl/mem_burst_reader.sv
// Burst reader: streams len words from a fixed-latency memory into a destination register.
// Optional BURST_ABORT_EN adds an abort input that stops issue and flushes buffered data.
module mem_burst_reader #(
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] len,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       dst_load,
  output logic [7:0] dst_data,
  input  logic       dst_ready,
`ifdef BURST_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | issuing reads, returns streaming to destination
  // DRAIN  | all reads issued, waiting for returns and FIFO to empty
  // FINISH | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t             state;
  logic [7:0]         addr_q;
  logic [8:0]         total;
  logic [8:0]         issued;
  logic [MEM_LAT-1:0] vld_sr;
  logic [MEM_LAT-1:0] vld_shift;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;
  logic [CW-1:0]      cnt_next;
  logic [7:0]         outstanding;
  logic [7:0]         occupancy;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               aborting;
  logic               abort_now;

`ifdef BURST_ABORT_EN
  assign abort_now = abort && ((state == RUN) || (state == DRAIN));

  // Remembers an abort so returns of reads still in flight are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborting <= 1'b0;
    end else if (abort_now) begin
      aborting <= 1'b1;
    end else if (state == FINISH) begin
      aborting <= 1'b0;
    end
  end
`else
  assign abort_now = 1'b0;
  assign aborting  = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      outstanding = outstanding + 8'(vld_sr[i]);
    end
  end

  assign occupancy  = outstanding + 8'(fifo_cnt);
  assign vld_shift  = vld_sr << 1;
  assign fifo_empty = (fifo_cnt == '0);

  assign mem_rd   = (state == RUN) && !abort_now && (issued < total) &&
                    (occupancy < 8'(FIFO_DEPTH));
  assign mem_addr = addr_q;
  assign dst_load = !fifo_empty && dst_ready && !abort_now;
  assign dst_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign push     = vld_sr[MEM_LAT-1] && !aborting && !abort_now;
  assign pop      = dst_load;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);

  always_comb begin
    cnt_next = fifo_cnt;
    if (push && !pop) begin
      cnt_next = fifo_cnt + CW'(1);
    end else if (pop && !push) begin
      cnt_next = fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      total    <= '0;
      issued   <= '0;
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      vld_sr <= MEM_LAT'({vld_sr, mem_rd});

      if (abort_now) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        fifo_cnt <= cnt_next;
      end

      if (mem_rd) begin
        addr_q <= addr_q + 8'd1;
        issued <= issued + 9'd1;
      end

      // Leave DRAIN on the cycle the last word leaves, so done follows it directly.
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            total  <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            issued <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort_now) begin
            state <= (vld_shift == '0) ? FINISH : DRAIN;
          end else if (mem_rd && (issued + 9'd1 == total)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_now) begin
            state <= (vld_shift == '0) ? FINISH : DRAIN;
          end else if ((vld_shift == '0) && (cnt_next == '0)) begin
            state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Scoreboard bench for mem_burst_reader: directed bursts against a fixed-latency memory model.
module tb_mem_burst_reader;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [7:0] len = 8'h00;
  logic       dst_ready = 1'b1;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       dst_load;
  logic [7:0] dst_data;
  logic       busy;
  logic       done;
`ifdef BURST_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_burst_reader #(.MEM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .dst_load(dst_load), .dst_data(dst_data), .dst_ready(dst_ready),
`ifdef BURST_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a * 8'd3 + 8'h11;
  endfunction

  // Memory model: data for a read appears LAT cycles after its strobe.
  logic [7:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mem_rd ? mem_addr : 8'hC3;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mem_data = mem_f(mpipe[LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_addr [$];
  logic [7:0] exp_data [$];
  int rd_cnt = 0, ld_cnt = 0, done_cnt = 0;
  bit expect_done = 0, first_pending = 0, chk_lat = 0, aborted = 0;
  int start_cyc = 0, last_ld_cyc = 0, abort_cyc = 0;

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (mem_rd) begin
      rd_cnt++;
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL rd_unexp: mem_addr=%h, required no read", mem_addr);
      end else begin
        e = exp_addr.pop_front();
        if (mem_addr !== e) begin
          errors++;
          $display("FAIL rd_addr: got %h, required %h", mem_addr, e);
        end
      end
    end
    if (dst_load) begin
      ld_cnt++;
      checks++;
      if (aborted) begin
        errors++;
        $display("FAIL ld_after_abort: dst_data=%h, required no load", dst_data);
      end else if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL ld_unexp: dst_data=%h, required no load", dst_data);
      end else begin
        e = exp_data.pop_front();
        if (dst_data !== e) begin
          errors++;
          $display("FAIL ld_data: got %h, required %h", dst_data, e);
        end
      end
      if (first_pending) begin
        first_pending = 0;
        if (chk_lat) begin
          checks++;
          if (cyc - start_cyc != LAT + 1) begin
            errors++;
            $display("FAIL first_lat: got %0d cycles, required %0d", cyc - start_cyc, LAT + 1);
          end
        end
      end
      last_ld_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      checks++;
      if (!expect_done) begin
        errors++;
        $display("FAIL done_unexp: done=1, required 0");
      end else if (aborted) begin
        if (cyc - abort_cyc > LAT) begin
          errors++;
          $display("FAIL abort_done: got %0d cycles, required <= %0d", cyc - abort_cyc, LAT);
        end
      end else if (exp_data.size() != 0) begin
        errors++;
        $display("FAIL done_early: %0d words left, required 0", exp_data.size());
      end else if (cyc != last_ld_cyc + 1) begin
        errors++;
        $display("FAIL done_gap: got %0d cycles after last load, required 1", cyc - last_ld_cyc);
      end
      expect_done = 0;
    end
  end

  task automatic start_burst(input logic [7:0] b, input logic [7:0] l);
    int n;
    logic [7:0] a;
    n = (l == 8'd0) ? 256 : int'(l);
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem_f(a));
    end
    expect_done = 1;
    first_pending = 1;
    base_addr = b;
    len = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input logic [7:0] pat);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      dst_ready = pat[k % 8];
      @(posedge clk); #1;
      k++;
    end
    dst_ready = 1'b1;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic wait_reads(input int base_cnt, input int n);
    int k;
    k = 0;
    while (rd_cnt - base_cnt < n && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (rd_cnt - base_cnt < n) begin
      errors++;
      $display("FAIL rd_wait: got %0d reads, required %0d", rd_cnt - base_cnt, n);
    end
  endtask

  initial begin
    int rd0, ld0, d0;

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_rd, dst_load, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl: got %b, required 0000", {mem_rd, dst_load, busy, done});
    end
    checks++;
    if ({mem_addr, dst_data} !== 16'h0000) begin
      errors++;
      $display("FAIL rst_bus: got %h, required 0000", {mem_addr, dst_data});
    end
    rst = 1'b0;
    @(posedge clk); #1;

    chk_lat = 1;
    start_burst(8'h10, 8'd3);
    wait_done(100, 8'hFF);

    start_burst(8'hFE, 8'd4);
    wait_done(100, 8'hFF);

    chk_lat = 0;
    start_burst(8'h05, 8'd6);
    wait_done(200, 8'b1011_0010);

    // Destination stalled: issue must stop at DEPTH words in flight or buffered.
    dst_ready = 1'b0;
    rd0 = rd_cnt;
    start_burst(8'h30, 8'd8);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1;
    base_addr = 8'h99;
    len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (rd_cnt - rd0 != DEPTH) begin
      errors++;
      $display("FAIL stall_rd: got %0d reads, required %0d", rd_cnt - rd0, DEPTH);
    end
    wait_done(200, 8'hFF);

    chk_lat = 1;
    ld0 = ld_cnt;
    start_burst(8'h80, 8'd0);
    wait_done(2000, 8'hFF);
    checks++;
    if (ld_cnt - ld0 != 256) begin
      errors++;
      $display("FAIL len0_loads: got %0d, required 256", ld_cnt - ld0);
    end

    // Reset in the middle of a burst.
    chk_lat = 0;
    rd0 = rd_cnt;
    start_burst(8'h40, 8'd8);
    wait_reads(rd0, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({mem_rd, dst_load, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b, required 0000", {mem_rd, dst_load, busy, done});
    end
    exp_addr.delete();
    exp_data.delete();
    expect_done = 0;
    first_pending = 0;
    ld0 = ld_cnt;
    d0 = done_cnt;
    repeat (12) begin @(posedge clk); #1; end
    checks++;
    if (ld_cnt != ld0 || done_cnt != d0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d loads %0d done, required 0 0", ld_cnt - ld0, done_cnt - d0);
    end

    chk_lat = 1;
    start_burst(8'hC8, 8'd5);
    wait_done(100, 8'hFF);

`ifdef BURST_ABORT_EN
    chk_lat = 0;
    rd0 = rd_cnt;
    start_burst(8'h20, 8'd10);
    wait_reads(rd0, 3);
    @(posedge clk); #1;
    abort = 1'b1;
    aborted = 1;
    abort_cyc = cyc;
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(50, 8'hFF);
    checks++;
    if (rd_cnt - rd0 != 3) begin
      errors++;
      $display("FAIL abort_rd: got %0d reads, required 3", rd_cnt - rd0);
    end
    aborted = 0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b, required 0", busy);
    end
    chk_lat = 1;
    start_burst(8'h60, 8'd2);
    wait_done(100, 8'hFF);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
